// File: rtl/dm_pkg.sv
// Shared constants, types and the masked-merge helper for the data-memory responder.
package dm_pkg;

  localparam int DM_ADDR_W = 14;
  localparam int DM_DATA_W = 32;

  typedef logic [DM_DATA_W-1:0] dm_word_t;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } dm_state_e;

  // Bits with bweb=0 take the new data; bits with bweb=1 keep the old word.
  function automatic dm_word_t dm_merge(dm_word_t old_word, dm_word_t di, dm_word_t bweb);
    return (old_word & bweb) | (di & ~bweb);
  endfunction

endpackage

// File: rtl/dm_init_ctrl.sv
// Post-reset clear sequencer: walks every word address once, then parks in ST_READY.
module dm_init_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W         = DM_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              init_busy
);

  dm_state_e         state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      if (CLEAR_ON_RESET) begin
        state_reg <= ST_CLEAR;
        busy_reg  <= 1'b1;
      end else begin
        state_reg <= ST_READY;
        busy_reg  <= 1'b0;
      end
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          // Counter wraps back to zero on the same edge that writes the last word.
          cnt_reg <= cnt_reg + 1'b1;
          if (&cnt_reg) begin
            state_reg <= ST_READY;
            busy_reg  <= 1'b0;
          end
        end
        ST_READY: begin
          state_reg <= ST_READY;
        end
        default: begin
          state_reg <= ST_READY;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign clear_we   = (state_reg == ST_CLEAR) && !rst;
  assign clear_addr = cnt_reg;
  assign init_busy  = busy_reg;

endmodule

// File: rtl/dm_sram_responder.sv
// Single-port data memory with bit-masked writes, registered reads and a post-reset clear.
module dm_sram_responder
  import dm_pkg::*;
#(
  parameter int                ADDR_W         = DM_ADDR_W,
  parameter int                DATA_W         = DM_DATA_W,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CEB,
  input  logic              WEB,
  input  logic [DATA_W-1:0] BWEB,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  output logic              init_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  dm_word_t          mem [DEPTH];
  dm_word_t          do_reg;
  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  dm_word_t          wr_data;
  dm_word_t          wr_mask;

  dm_init_ctrl #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_init_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .init_busy  (init_busy)
  );

  // One write path: the clear sequencer owns it while busy, the CPU port afterwards.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = A;
    wr_data = DI;
    wr_mask = BWEB;
    if (clear_we) begin
      wr_en   = 1'b1;
      wr_addr = clear_addr;
      wr_data = INIT_VALUE;
      wr_mask = '0;
    end else if (!rst && !init_busy && !CEB && !WEB) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= dm_merge(mem[wr_addr], wr_data, wr_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      do_reg <= '0;
    end else if (!init_busy && !CEB && WEB) begin
      do_reg <= mem[A];
    end
  end

  assign DO = do_reg;

endmodule
